// File: rtl/dpram_pkg.sv
// Shared definitions for the byte-enable dual-port RAM with clear engine.
package dpram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_t;

    function automatic int nb_lanes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/dpram_be_core.sv
// Read-first true dual-port storage, one inferred array per byte lane, no reset.
module dpram_be_core #(
    parameter int AW = 10,
    parameter int NB = 2
) (
    input  logic            clock,
    input  logic [NB-1:0]   i_we_a,
    input  logic [AW-1:0]   i_addr_a,
    input  logic [8*NB-1:0] i_din_a,
    output logic [8*NB-1:0] o_q_a,
    input  logic [NB-1:0]   i_we_b,
    input  logic [AW-1:0]   i_addr_b,
    input  logic [8*NB-1:0] i_din_b,
    output logic [8*NB-1:0] o_q_b
);

    for (genvar g = 0; g < NB; g++) begin : g_lane
        logic [7:0] r_mem [0:2**AW-1];
        logic [7:0] r_q_a;
        logic [7:0] r_q_b;

        // Same-address collisions are resolved upstream, so the two writes never overlap.
        always_ff @(posedge clock) begin
            if (i_we_a[g]) r_mem[i_addr_a] <= i_din_a[8*g +: 8];
            if (i_we_b[g]) r_mem[i_addr_b] <= i_din_b[8*g +: 8];
            r_q_a <= r_mem[i_addr_a];
            r_q_b <= r_mem[i_addr_b];
        end

        assign o_q_a[8*g +: 8] = r_q_a;
        assign o_q_b[8*g +: 8] = r_q_b;
    end

endmodule

// File: rtl/dpram_be_clr.sv
// Dual-port byte-enable RAM with a self-clearing engine that fills every word with CLRVAL.
//   state    | meaning
//   ST_IDLE  | normal access; waits for synchronised reset release or clr_req
//   ST_CLEAR | writes CLRVAL at cnt, ports blocked, busy=1
//   ST_DONE  | one-cycle epilogue before returning to IDLE
module dpram_be_clr
    import dpram_pkg::*;
#(
    parameter int              AW     = 10,
    parameter int              DW     = 16,
    parameter int              OREG   = 0,
    parameter logic [DW-1:0]   CLRVAL = '0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      clr_req,
    output logic                      busy,
    input  logic                      wren_a,
    input  logic [nb_lanes(DW)-1:0]   byteena_a,
    input  logic [AW-1:0]             address_a,
    input  logic [DW-1:0]             data_a,
    output logic [DW-1:0]             q_a,
    input  logic                      wren_b,
    input  logic [nb_lanes(DW)-1:0]   byteena_b,
    input  logic [AW-1:0]             address_b,
    input  logic [DW-1:0]             data_b,
    output logic [DW-1:0]             q_b
);

    localparam int NB = nb_lanes(DW);

    clr_state_t    r_state;
    clr_state_t    w_state_nxt;
    logic [AW:0]   r_cnt;
    logic [AW:0]   w_cnt_inc;
    logic [1:0]    r_sync;
    logic          r_init_pend;
    logic          r_qen;
    logic          w_trig;
    logic [NB-1:0] w_col;
    logic [NB-1:0] w_we_a;
    logic [NB-1:0] w_we_b;
    logic [AW-1:0] w_addr_a;
    logic [DW-1:0] w_din_a;
    logic [DW-1:0] w_core_q_a;
    logic [DW-1:0] w_core_q_b;
    logic [DW-1:0] w_rd_a;
    logic [DW-1:0] w_rd_b;
    logic [DW-1:0] w_pipe_a;
    logic [DW-1:0] w_pipe_b;

    assign busy      = (r_state == ST_CLEAR);
    assign w_cnt_inc = r_cnt + {{AW{1'b0}}, 1'b1};
    assign w_trig    = r_sync[1] & (r_init_pend | clr_req);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_trig) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (w_cnt_inc[AW]) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // r_qen masks the never-initialised array contents until the first clear completes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync      <= '0;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_init_pend <= 1'b1;
            r_qen       <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], 1'b1};
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == ST_CLEAR) ? w_cnt_inc : '0;
            if (r_state == ST_CLEAR) r_init_pend <= 1'b0;
            if (r_state == ST_CLEAR && w_cnt_inc[AW]) r_qen <= 1'b1;
        end
    end

    // Port A owns any lane both ports write at the same address.
    assign w_col    = (wren_a && (address_a == address_b)) ? byteena_a : '0;
    assign w_we_a   = busy ? {NB{1'b1}} : (wren_a ? byteena_a : '0);
    assign w_addr_a = busy ? r_cnt[AW-1:0] : address_a;
    assign w_din_a  = busy ? CLRVAL : data_a;
    assign w_we_b   = busy ? '0 : (wren_b ? (byteena_b & ~w_col) : '0);

    dpram_be_core #(
        .AW (AW),
        .NB (NB)
    ) u_core (
        .clock    (clock),
        .i_we_a   (w_we_a),
        .i_addr_a (w_addr_a),
        .i_din_a  (w_din_a),
        .o_q_a    (w_core_q_a),
        .i_we_b   (w_we_b),
        .i_addr_b (address_b),
        .i_din_b  (data_b),
        .o_q_b    (w_core_q_b)
    );

    assign w_rd_a = r_qen ? w_core_q_a : '0;
    assign w_rd_b = r_qen ? w_core_q_b : '0;

    if (OREG != 0) begin : g_oreg
        logic [DW-1:0] r_q_a;
        logic [DW-1:0] r_q_b;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_q_a <= '0;
                r_q_b <= '0;
            end else begin
                r_q_a <= w_rd_a;
                r_q_b <= w_rd_b;
            end
        end

        assign w_pipe_a = r_q_a;
        assign w_pipe_b = r_q_b;
    end else begin : g_noreg
        assign w_pipe_a = w_rd_a;
        assign w_pipe_b = w_rd_b;
    end

    assign q_a = busy ? '0 : w_pipe_a;
    assign q_b = busy ? '0 : w_pipe_b;

endmodule
